md_seq_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the EX stage. It owns an iterative shift-add multiplier and a restoring divider.
- Raises the EX stall request while an operation is in progress.
- Presents the 64-bit HI/LO result for one handshake so EX can place it on the hilo bus that flows through MEM to WB.
- One operation is in flight at a time. A pipeline flush cancels it.

---
 rtl/md_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_md_seq_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: iterative multiply/divide sequencer for EX (shift-add multiplier, restoring divider)
// Ports: clk/rst (sync, active-high); flush cancels the in-flight op; start/op/src_a/src_b
// present a MULT/MULTU/DIV/DIVU from EX; hold is the downstream stall; stallreq freezes PC..EX;
// busy = not idle; res_valid marks the DONE cycle(s); hi/lo carry the 64-bit HI/LO result.
module md_seq_ctrl #(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hold,
    output logic        stallreq,
    output logic        busy,
    output logic        res_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sq_q, sq_d, sr_q, sr_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        sgn, early;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum, trial;
    logic [63:0] mul_next;
    logic        ge;
    logic [31:0] quo_next, rem_next;
    assign sgn   = ~op[0];
    assign mag_a = (sgn & src_a[31]) ? -src_a : src_a;
    assign mag_b = (sgn & src_b[31]) ? -src_b : src_b;
    assign early = EARLY_ZERO && op[1] && (src_b == 32'd0);
    // multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step
    assign sum      = {1'b0, acc_q[63:32]} + {1'b0, acc_q[0] ? b_q : 32'd0};
    assign mul_next = {sum, acc_q[31:1]};
    // divide: acc[31:0] shifts dividend bits out while quotient bits shift in
    assign trial    = {rem_q, acc_q[31]};
    assign ge       = trial >= {1'b0, b_q};
    assign rem_next = ge ? trial[31:0] - b_q : trial[31:0];
    assign quo_next = {acc_q[30:0], ge};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            acc_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_d  = op;
                    sq_d  = sgn & (src_a[31] ^ src_b[31]);
                    sr_d  = sgn & src_a[31];
                    cnt_d = '0;
                    if (early) begin
                        state_d = DONE;
                        hi_d    = src_a;
                        lo_d    = 32'hFFFF_FFFF;
                    end else begin
                        state_d = RUN;
                        b_d     = op[1] ? mag_b : mag_a;
                        acc_d   = {32'd0, op[1] ? mag_a : mag_b};
                        rem_d   = '0;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + 5'd1;
                    acc_d = op_q[1] ? {32'd0, quo_next} : mul_next;
                    rem_d = op_q[1] ? rem_next : rem_q;
                    if (cnt_q == 5'd31) begin
                        state_d      = DONE;
                        {hi_d, lo_d} = op_q[1] ? {sr_q ? -rem_next : rem_next, sq_q ? -quo_next : quo_next}
                                               : (sq_q ? -mul_next : mul_next);
                    end
                end
                DONE: state_d = hold ? DONE : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
    assign stallreq  = ~flush & (((state_q == IDLE) & start & ~early) | (state_q == RUN));
    assign busy      = state_q != IDLE;
    assign res_valid = state_q == DONE;
    assign hi        = hi_q;
    assign lo        = lo_q;
endmodule

// File: tb/tb_md_seq_ctrl.sv
// tb_md_seq_ctrl: scoreboard bench for md_seq_ctrl
module tb_md_seq_ctrl;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, start = 1'b0, hold = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        stallreq, busy, res_valid;
    logic [31:0] hi, lo;
    int          vectors = 0, miscompares = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last;

    always #5 clk = ~clk;

    md_seq_ctrl #(.EARLY_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .hold(hold), .stallreq(stallreq),
        .busy(busy), .res_valid(res_valid), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p  = o[0] ? ua * ub : sa * sb;
        longint q  = sa / sb;
        longint r  = sa % sb;
        if (!o[1]) return p;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o[0]) return {a % b, a / b};
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold_n, input bit early);
        int n = 0, stalls = 0;
        logic [63:0] e;
        sb_q.push_back(exp);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        while (!res_valid && n < 100) begin
            stalls += int'(stallreq);
            step;
            n++;
            if (n == 5) begin
                src_a = $urandom;
                src_b = $urandom | 32'd1;
                op    = ~o;
            end
        end
        chk("latency", 64'(n), early ? 64'd1 : 64'd33);
        chk("stall_cycles", 64'(stalls), early ? 64'd0 : 64'd33);
        e = sb_q.pop_front();
        chk("result", {hi, lo}, e);
        hold = hold_n > 0;
        for (int i = 0; i < hold_n; i++) begin
            step;
            chk("hold_flags", {61'd0, res_valid, stallreq, busy}, 64'b101);
            chk("hold_data", {hi, lo}, e);
            if (i == hold_n - 1) hold = 1'b0;
        end
        step;
        start = 1'b0;
        #1;
        chk("back_idle", {61'd0, res_valid, busy, stallreq}, 64'd0);
        chk("keep_data", {hi, lo}, e);
    endtask

    initial begin
        step;
        step;
        chk("reset", {29'd0, stallreq, busy, res_valid, hi, lo}, 64'd0);
        rst = 1'b0;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 0, 1'b1);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 0, 1'b1);
        run_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 3, 1'b0);
        last = {hi, lo};
        op = 2'b00; src_a = 32'd123; src_b = 32'd456; start = 1'b1;
        for (int i = 0; i < 11; i++) step;
        chk("run_stall", {63'd0, stallreq}, 64'd1);
        flush = 1'b1;
        #1;
        chk("flush_stall", {63'd0, stallreq}, 64'd0);
        step;
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush_idle", {62'd0, busy, res_valid}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("flush_novalid", {63'd0, res_valid}, 64'd0);
        end
        chk("flush_keep", {hi, lo}, last);
        start = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_start_stall", {63'd0, stallreq}, 64'd0);
        step;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        flush = 1'b0;
        run_op(2'b11, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op(o, a, b, model(o, a, b), int'($urandom_range(0, 2)), o[1] && b == 32'd0);
        end
        op = 2'b01; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        for (int i = 0; i < 5; i++) step;
        rst = 1'b1;
        start = 1'b0;
        step;
        chk("reset_run", {29'd0, stallreq, busy, res_valid, hi, lo}, 64'd0);
        rst = 1'b0;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
